// File: rtl/hdmi_read_scheduler.sv
// Turns hdmi_core frame/line/chunk pulses into fixed-size frame-buffer read bursts.
// Optional HDMI_READ_PREFETCH_EN: each line's first burst is issued without waiting for a chunk pulse.
module hdmi_read_scheduler #(
  parameter int NUM_BYTES_PER_PIXEL = 2,
  parameter int HRES                = 1280,
  parameter int VRES                = 720,
  parameter int BURST_BYTES         = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] frame_base,
  input  logic        read_go,
  input  logic        read_next_line,
  input  logic        read_next_chunk,
  input  logic        read_done,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_len,
  input  logic        mem_ack,
  output logic        frame_active,
  output logic [11:0] line_count,
  output logic        overrun
);

  localparam int LINE_BYTES = HRES * NUM_BYTES_PER_PIXEL;
  localparam int CPL        = LINE_BYTES / BURST_BYTES;
  localparam int CW         = $clog2(CPL + 1);
  localparam logic [2:0] MAX_PENDING = 3'd4;

`ifdef HDMI_READ_PREFETCH_EN
  localparam logic [2:0] LINE_PRESET = 3'd1;
  localparam logic       LINE_ABSORB = 1'b1;
`else
  localparam logic [2:0] LINE_PRESET = 3'd0;
  localparam logic       LINE_ABSORB = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LINE_RUN, LINE_WAIT, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   line_addr_reg, line_addr_next;
  logic [CW-1:0] chunk_idx_reg, chunk_idx_next;
  logic [11:0]   line_count_reg, line_count_next;
  logic [2:0]    pending_reg, pending_next;
  logic          line_pending_reg, line_pending_next;
  logic          absorb_reg, absorb_next;
  logic          frame_active_reg, frame_active_next;
  logic          overrun_reg, overrun_next;
  logic          mem_req_reg, mem_req_next;
  logic [31:0]   mem_addr_reg, mem_addr_next;

  logic          accept;
  logic          chunk_take;
  logic [31:0]   in_flight;
  logic          last_line;

  assign accept    = mem_req_reg & mem_ack;
  // pending includes the request currently on the bus, so this is issued + requested
  assign in_flight = 32'(chunk_idx_reg) + 32'(pending_reg);
  assign last_line = (line_count_reg == 12'(VRES - 1));

  always_comb begin
    state_next        = state_reg;
    line_addr_next    = line_addr_reg;
    chunk_idx_next    = chunk_idx_reg;
    line_count_next   = line_count_reg;
    pending_next      = pending_reg;
    line_pending_next = line_pending_reg;
    absorb_next       = absorb_reg;
    frame_active_next = frame_active_reg;
    overrun_next      = overrun_reg;
    mem_req_next      = mem_req_reg;
    mem_addr_next     = mem_addr_reg;
    chunk_take        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (read_go) begin
          line_addr_next    = frame_base;
          chunk_idx_next    = '0;
          line_count_next   = '0;
          pending_next      = LINE_PRESET;
          absorb_next       = LINE_ABSORB;
          line_pending_next = 1'b0;
          frame_active_next = 1'b1;
          overrun_next      = 1'b0;
          state_next        = LINE_RUN;
        end
      end

      LINE_RUN, LINE_WAIT: begin
        if (read_done) begin
          pending_next      = '0;
          line_pending_next = 1'b0;
          absorb_next       = 1'b0;
          if (mem_req_reg && !mem_ack) begin
            state_next = DRAIN;
          end else begin
            mem_req_next      = 1'b0;
            frame_active_next = 1'b0;
            state_next        = IDLE;
          end
        end else begin
          if (read_next_chunk) begin
            if (absorb_reg) begin
              absorb_next = 1'b0;
            end else if (pending_reg >= MAX_PENDING || in_flight >= 32'(CPL)) begin
              overrun_next = 1'b1;
            end else begin
              chunk_take = 1'b1;
            end
          end
          pending_next = pending_reg + {2'b00, chunk_take} - {2'b00, accept};

          // a request always drops for one cycle after acceptance before the next one
          if (accept) begin
            mem_req_next   = 1'b0;
            chunk_idx_next = chunk_idx_reg + 1'b1;
          end else if (!mem_req_reg && pending_reg != 3'd0) begin
            mem_req_next  = 1'b1;
            mem_addr_next = line_addr_reg + 32'(chunk_idx_reg) * 32'(BURST_BYTES);
          end

          if (read_next_line) begin
            line_pending_next = 1'b1;
          end
          if (state_reg == LINE_RUN && accept && chunk_idx_reg == CW'(CPL - 1)) begin
            state_next = LINE_WAIT;
          end

          if (state_reg == LINE_WAIT && (read_next_line || line_pending_reg)) begin
            line_pending_next = 1'b0;
            if (last_line) begin
              pending_next      = '0;
              absorb_next       = 1'b0;
              frame_active_next = 1'b0;
              state_next        = IDLE;
            end else begin
              line_addr_next  = line_addr_reg + 32'(LINE_BYTES);
              chunk_idx_next  = '0;
              line_count_next = line_count_reg + 12'd1;
              pending_next    = LINE_PRESET;
              absorb_next     = LINE_ABSORB;
              state_next      = LINE_RUN;
            end
          end
        end
      end

      DRAIN: begin
        if (accept) begin
          mem_req_next      = 1'b0;
          frame_active_next = 1'b0;
          state_next        = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      line_addr_reg    <= '0;
      chunk_idx_reg    <= '0;
      line_count_reg   <= '0;
      pending_reg      <= '0;
      line_pending_reg <= 1'b0;
      absorb_reg       <= 1'b0;
      frame_active_reg <= 1'b0;
      overrun_reg      <= 1'b0;
      mem_req_reg      <= 1'b0;
      mem_addr_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      line_addr_reg    <= line_addr_next;
      chunk_idx_reg    <= chunk_idx_next;
      line_count_reg   <= line_count_next;
      pending_reg      <= pending_next;
      line_pending_reg <= line_pending_next;
      absorb_reg       <= absorb_next;
      frame_active_reg <= frame_active_next;
      overrun_reg      <= overrun_next;
      mem_req_reg      <= mem_req_next;
      mem_addr_reg     <= mem_addr_next;
    end
  end

  assign mem_req      = mem_req_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_len      = 8'(BURST_BYTES);
  assign frame_active = frame_active_reg;
  assign line_count   = line_count_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_hdmi_read_scheduler.sv
// Testbench for hdmi_read_scheduler: memory responder, burst log and a frame-level address model.
`timescale 1ns/1ps
module tb_hdmi_read_scheduler;

  localparam int HRES_TB   = 1280;
  localparam int NBPP_TB   = 2;
  localparam int BURST_TB  = 64;
  localparam int VRES_TB   = 2;
  localparam int LINE_B    = HRES_TB * NBPP_TB;
  localparam int CPL_TB    = LINE_B / BURST_TB;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] frame_base = '0;
  logic        read_go = 1'b0;
  logic        read_next_line = 1'b0;
  logic        read_next_chunk = 1'b0;
  logic        read_done = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_ack = 1'b0;
  logic        frame_active;
  logic [11:0] line_count;
  logic        overrun;

  always #5 clock = ~clock;

  hdmi_read_scheduler #(
    .NUM_BYTES_PER_PIXEL(NBPP_TB),
    .HRES(HRES_TB),
    .VRES(VRES_TB),
    .BURST_BYTES(BURST_TB)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .frame_base(frame_base),
    .read_go(read_go),
    .read_next_line(read_next_line),
    .read_next_chunk(read_next_chunk),
    .read_done(read_done),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_len(mem_len),
    .mem_ack(mem_ack),
    .frame_active(frame_active),
    .line_count(line_count),
    .overrun(overrun)
  );

  int          checks = 0;
  int          failures = 0;
  int          ack_delay = 1;
  bit          ack_block = 1'b0;
  int          wait_cnt = 0;
  bit          prev_req = 1'b0;
  bit          prev_acc = 1'b0;
  logic [31:0] prev_addr = '0;
  int          gap_err = 0;
  int          stable_err = 0;
  int          len_err = 0;
  logic [31:0] got_q[$];
  int          frame_start_n = 0;

  // Memory side: acks after ack_delay cycles of mem_req, logs each burst and protocol slips.
  always @(negedge clock) begin
    if (!reset_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      prev_req = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (prev_acc && mem_req) gap_err++;
      if (prev_req && !prev_acc && (!mem_req || mem_addr !== prev_addr)) stable_err++;
      prev_req  = mem_req;
      prev_addr = mem_addr;
      if (mem_req && !ack_block && wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        got_q.push_back(mem_addr);
        if (mem_len !== 8'(BURST_TB)) len_err++;
        $display("burst %0d addr=%h len=%0d", got_q.size() - 1, mem_addr, mem_len);
      end else begin
        mem_ack = 1'b0;
        if (mem_req && !ack_block) wait_cnt++;
        else wait_cnt = 0;
      end
      prev_acc = mem_ack;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // sel: 0 read_go, 1 read_next_chunk, 2 read_next_line, 3 read_done
  task automatic pulse(input int sel);
    @(posedge clock); #1;
    case (sel)
      0: read_go = 1'b1;
      1: read_next_chunk = 1'b1;
      2: read_next_line = 1'b1;
      default: read_done = 1'b1;
    endcase
    @(posedge clock); #1;
    read_go = 1'b0;
    read_next_chunk = 1'b0;
    read_next_line = 1'b0;
    read_done = 1'b0;
  endtask

  task automatic wait_bursts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(3);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (frame_active !== 1'b0) begin failures++; $display("FAIL reset_frame_active got=%b want=0", frame_active); end
    checks++; if (line_count !== 12'd0) begin failures++; $display("FAIL reset_line_count got=%0d want=0", line_count); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    reset_n = 1'b1;
    cycles(2);
    checks++; if (mem_len !== 8'(BURST_TB)) begin failures++; $display("FAIL mem_len got=%0d want=%0d", mem_len, BURST_TB); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_mem_req got=%b want=0", mem_req); end
  endtask

  task automatic test_first_bursts();
    bit ok;
    logic [31:0] exp;
    ack_block = 1'b0;
    ack_delay = 1;
    frame_start_n = got_q.size();
    frame_base = 32'h1000_0000;
    pulse(0);
    checks++; if (frame_active !== 1'b1) begin failures++; $display("FAIL go_frame_active got=%b want=1", frame_active); end
    checks++; if (line_count !== 12'd0) begin failures++; $display("FAIL go_line_count got=%0d want=0", line_count); end
    for (int k = 0; k < 3; k++) begin
      pulse(1);
      cycles(4);
    end
    wait_bursts(frame_start_n + 3, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL first_bursts_timeout got=%0d want=%0d", got_q.size() - frame_start_n, 3); end
    cycles(10);
    checks++; if (got_q.size() !== frame_start_n + 3) begin failures++; $display("FAIL first_bursts_count got=%0d want=3", got_q.size() - frame_start_n); end
    for (int k = 0; k < 3 && frame_start_n + k < got_q.size(); k++) begin
      exp = 32'h1000_0000 + 32'(k * BURST_TB);
      checks++; if (got_q[frame_start_n + k] !== exp) begin failures++; $display("FAIL first_burst_addr%0d got=%h want=%h", k, got_q[frame_start_n + k], exp); end
    end
  endtask

  task automatic test_line_advance();
    bit ok;
    for (int k = 3; k < CPL_TB; k++) begin
      pulse(1);
      cycles($urandom_range(3, 8));
    end
    wait_bursts(frame_start_n + CPL_TB, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL line0_timeout got=%0d want=%0d", got_q.size() - frame_start_n, CPL_TB); end
    cycles(5);
    checks++; if (got_q.size() !== frame_start_n + CPL_TB) begin failures++; $display("FAIL line0_count got=%0d want=%0d", got_q.size() - frame_start_n, CPL_TB); end
    if (got_q.size() >= frame_start_n + CPL_TB) begin
      checks++; if (got_q[frame_start_n + CPL_TB - 1] !== 32'h1000_09C0) begin failures++; $display("FAIL line0_last_addr got=%h want=100009c0", got_q[frame_start_n + CPL_TB - 1]); end
    end
    checks++; if (line_count !== 12'd0) begin failures++; $display("FAIL pre_line_count got=%0d want=0", line_count); end
    pulse(2);
    cycles(2);
    checks++; if (line_count !== 12'd1) begin failures++; $display("FAIL line_count_adv got=%0d want=1", line_count); end
    pulse(1);
    wait_bursts(frame_start_n + CPL_TB + 1, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL line1_timeout got=%0d want=%0d", got_q.size() - frame_start_n, CPL_TB + 1); end
    if (ok) begin
      checks++; if (got_q[frame_start_n + CPL_TB] !== 32'h1000_0A00) begin failures++; $display("FAIL line1_addr got=%h want=10000a00", got_q[frame_start_n + CPL_TB]); end
    end
    pulse(3);
    cycles(3);
    checks++; if (frame_active !== 1'b0) begin failures++; $display("FAIL done_frame_active got=%b want=0", frame_active); end
  endtask

  task automatic test_overrun();
    bit ok;
    int nb;
    logic [31:0] base;
    logic [31:0] exp;
    base = $urandom() & 32'hFFFF_FFC0;
    nb = got_q.size();
    ack_block = 1'b1;
    ack_delay = 0;
    frame_base = base;
    pulse(0);
    for (int k = 0; k < 4; k++) pulse(1);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_after4 got=%b want=0", overrun); end
    pulse(1);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_after5 got=%b want=1", overrun); end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL stalled_req got=%b want=1", mem_req); end
    checks++; if (mem_addr !== base) begin failures++; $display("FAIL stalled_addr got=%h want=%h", mem_addr, base); end
    ack_block = 1'b0;
    wait_bursts(nb + 4, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL overrun_bursts_timeout got=%0d want=4", got_q.size() - nb); end
    cycles(20);
    checks++; if (got_q.size() !== nb + 4) begin failures++; $display("FAIL overrun_burst_count got=%0d want=4", got_q.size() - nb); end
    for (int k = 0; k < 4 && nb + k < got_q.size(); k++) begin
      exp = base + 32'(k * BURST_TB);
      checks++; if (got_q[nb + k] !== exp) begin failures++; $display("FAIL overrun_addr%0d got=%h want=%h", k, got_q[nb + k], exp); end
    end
    pulse(3);
    cycles(3);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_done_drain();
    bit ok;
    int nb;
    logic [31:0] base;
    base = $urandom() & 32'hFFFF_FFC0;
    nb = got_q.size();
    ack_block = 1'b1;
    ack_delay = 0;
    frame_base = base;
    pulse(0);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL go_clears_overrun got=%b want=0", overrun); end
    pulse(1);
    wait_req(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drain_req_timeout got=%b want=1", mem_req); end
    pulse(3);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL drain_req_held got=%b want=1", mem_req); end
    checks++; if (frame_active !== 1'b1) begin failures++; $display("FAIL drain_frame_active got=%b want=1", frame_active); end
    cycles(2);
    ack_block = 1'b0;
    wait_bursts(nb + 1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL drain_burst_timeout got=%0d want=1", got_q.size() - nb); end
    cycles(3);
    checks++; if (frame_active !== 1'b0) begin failures++; $display("FAIL drain_idle_frame_active got=%b want=0", frame_active); end
    if (ok) begin
      checks++; if (got_q[nb] !== base) begin failures++; $display("FAIL drain_addr got=%h want=%h", got_q[nb], base); end
    end
    pulse(1);
    cycles(10);
    checks++; if (got_q.size() !== nb + 1) begin failures++; $display("FAIL drain_extra_bursts got=%0d want=1", got_q.size() - nb); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL drain_req_after got=%b want=0", mem_req); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int nb;
    logic [31:0] base;
    ack_block = 1'b1;
    ack_delay = 0;
    frame_base = $urandom() & 32'hFFFF_FFC0;
    pulse(0);
    pulse(1);
    wait_req(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_req_timeout got=%b want=1", mem_req); end
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_async_req got=%b want=0", mem_req); end
    checks++; if (frame_active !== 1'b0) begin failures++; $display("FAIL rst_async_active got=%b want=0", frame_active); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_async_addr got=%h want=0", mem_addr); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    ack_block = 1'b0;
    nb = got_q.size();
    cycles(10);
    checks++; if (got_q.size() !== nb) begin failures++; $display("FAIL rst_no_burst got=%0d want=0", got_q.size() - nb); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_idle_req got=%b want=0", mem_req); end
    base = $urandom() & 32'hFFFF_FFC0;
    frame_base = base;
    pulse(0);
    pulse(1);
    wait_bursts(nb + 1, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_restart_timeout got=%0d want=1", got_q.size() - nb); end
    if (ok) begin
      checks++; if (got_q[nb] !== base) begin failures++; $display("FAIL rst_restart_addr got=%h want=%h", got_q[nb], base); end
    end
    cycles(3);
    pulse(3);
    cycles(3);
  endtask

  task automatic test_prefetch();
    int nb;
    logic [31:0] base;
    base = $urandom() & 32'hFFFF_FFC0;
    nb = got_q.size();
    ack_block = 1'b0;
    ack_delay = 1;
    frame_base = base;
    pulse(0);
    cycles(12);
`ifdef HDMI_READ_PREFETCH_EN
    checks++; if (got_q.size() !== nb + 1) begin failures++; $display("FAIL prefetch_count got=%0d want=1", got_q.size() - nb); end
    if (got_q.size() > nb) begin
      checks++; if (got_q[nb] !== base) begin failures++; $display("FAIL prefetch_addr got=%h want=%h", got_q[nb], base); end
    end
`else
    checks++; if (got_q.size() !== nb) begin failures++; $display("FAIL prefetch_count got=%0d want=0", got_q.size() - nb); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL prefetch_req got=%b want=0", mem_req); end
`endif
    pulse(3);
    cycles(3);
    checks++; if (frame_active !== 1'b0) begin failures++; $display("FAIL prefetch_done_active got=%b want=0", frame_active); end
  endtask

  // Whole frames with random base (one near the top of memory), pacing, ack latency and extra chunks.
  task automatic test_random_frames();
    bit ok;
    bit early;
    int nb;
    int extras;
    int extras_total;
    logic [31:0] base;
    logic [31:0] exp_q[$];
    for (int f = 0; f < 3; f++) begin
      base = (f == 1) ? 32'hFFFF_F800 : ($urandom() & 32'hFFFF_FFC0);
      exp_q = {};
      extras_total = 0;
      nb = got_q.size();
      ack_block = 1'b0;
      ack_delay = 0;
      frame_base = base;
      pulse(0);
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rnd%0d_start_overrun got=%b want=0", f, overrun); end
      checks++; if (frame_active !== 1'b1) begin failures++; $display("FAIL rnd%0d_start_active got=%b want=1", f, frame_active); end
      for (int l = 0; l < VRES_TB; l++) begin
        for (int k = 0; k < CPL_TB; k++) exp_q.push_back(base + 32'(l * LINE_B) + 32'(k * BURST_TB));
        for (int k = 0; k < CPL_TB; k++) begin
          ack_delay = $urandom_range(0, 3);
          pulse(1);
          cycles($urandom_range(3, 8));
        end
        extras = (f == 0 && l == 0) ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
        for (int e = 0; e < extras; e++) pulse(1);
        extras_total += extras;
        early = (l < VRES_TB - 1) && ($urandom_range(0, 1) == 1);
        if (early) pulse(2);
        wait_bursts(nb + (l + 1) * CPL_TB, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_line%0d_timeout got=%0d want=%0d", f, l, got_q.size() - nb, (l + 1) * CPL_TB); end
        if (!early) pulse(2);
        cycles(3);
        if (l < VRES_TB - 1) begin
          checks++; if (line_count !== 12'(l + 1)) begin failures++; $display("FAIL rnd%0d_line_count got=%0d want=%0d", f, line_count, l + 1); end
        end
      end
      cycles(5);
      checks++; if (frame_active !== 1'b0) begin failures++; $display("FAIL rnd%0d_end_active got=%b want=0", f, frame_active); end
      checks++; if (line_count !== 12'(VRES_TB - 1)) begin failures++; $display("FAIL rnd%0d_end_line_count got=%0d want=%0d", f, line_count, VRES_TB - 1); end
      checks++; if (overrun !== (extras_total > 0)) begin failures++; $display("FAIL rnd%0d_overrun got=%b want=%b", f, overrun, extras_total > 0); end
      checks++; if (got_q.size() !== nb + exp_q.size()) begin failures++; $display("FAIL rnd%0d_count got=%0d want=%0d", f, got_q.size() - nb, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && nb + i < got_q.size(); i++) begin
        checks++; if (got_q[nb + i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_addr%0d got=%h want=%h", f, i, got_q[nb + i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_protocol();
    checks++; if (gap_err !== 0) begin failures++; $display("FAIL req_gap got=%0d want=0", gap_err); end
    checks++; if (stable_err !== 0) begin failures++; $display("FAIL req_stable got=%0d want=0", stable_err); end
    checks++; if (len_err !== 0) begin failures++; $display("FAIL burst_len got=%0d want=0", len_err); end
  endtask

  initial begin
    test_reset();
    test_first_bursts();
    test_line_advance();
    test_overrun();
    test_done_drain();
    test_reset_mid_burst();
    test_prefetch();
    test_random_frames();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
